seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_pkg.sv | 27 ++
 rtl/seg_scan_tick.sv | 53 +++++
 rtl/seg_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared types and constants for the multiplexed segment scan controller.
//   NUM_POS    : display positions per frame (two per stored value)
//   NUM_VALUES : stored 4-bit values (each drives a tens and a ones position)
//   value_t    : one 4-bit display value
//   vidx_t     : index into a value bank
//   pos_t      : display position 0..NUM_POS-1
//   lz_blank() : leading-zero blanking rule, used when SEG_SCAN_LZ_BLANK_EN
//                is defined in the top level
// -----------------------------------------------------------------------------
package seg_scan_pkg;

  localparam int NUM_POS    = 8;
  localparam int NUM_VALUES = 4;

  typedef logic [3:0]                     value_t;
  typedef logic [$clog2(NUM_VALUES)-1:0]  vidx_t;
  typedef logic [$clog2(NUM_POS)-1:0]     pos_t;

  // A tens digit below ten is a leading zero of a two-digit display value
  // (values A..F still show a tens digit on the decoder side).
  function automatic logic lz_blank(input logic place, input value_t v);
    return place & (v < 4'd10);
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// -----------------------------------------------------------------------------
// seg_scan_tick
// Dwell divider: counts 0..SCAN_DIV-1 while enabled and flags the terminal
// count. The count freezes while en_i is low.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   en_i    : count enable
//   tick_o  : high in the cycle where the divider sits at its terminal count
//             and en_i is high (one cycle per dwell period)
// -----------------------------------------------------------------------------
module seg_scan_tick #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  // Keep at least one bit so SCAN_DIV=1 still builds; the counter then stays 0.
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] TERM = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          term_s;

  // Next-state of the divider and terminal-count detection.
  always_comb begin
    div_d  = div_q;
    term_s = (div_q == TERM);
    if (!en_i) begin
      div_d = div_q;
    end else if (term_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  assign tick_o = en_i & term_s;

  // Divider register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Eight-position display scanner over four double-buffered 4-bit values.
// Software writes the shadow bank at any time and requests a commit with
// UPDATE; the commit is applied only at a frame boundary so a frame never
// shows a mix of old and new values.
// Ports:
//   CLK        : clock, rising edge
//   RST_N      : asynchronous active-low reset
//   EN         : scan enable; low freezes divider, SELECT, UPD_PEND, active bank
//   WR_EN      : shadow write strobe
//   WR_ADDR    : shadow index 0..3
//   WR_DATA    : shadow value
//   UPDATE     : commit request (shadow -> active at next frame boundary)
//   DIGIT      : registered active value for the current position
//   SELECT     : current position 0..7
//   PLACE      : registered, 1 = tens position, 0 = ones position
//   BLANK      : registered position suppress
//   UPD_PEND   : commit requested, not yet applied
//   FRAME_DONE : one-cycle pulse after each 7->0 wrap
// Configuration:
//   SEG_SCAN_LZ_BLANK_EN : when defined, BLANK suppresses tens digits below 10;
//                          otherwise BLANK is always 0.
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       WR_EN,
  input  logic [1:0] WR_ADDR,
  input  logic [3:0] WR_DATA,
  input  logic       UPDATE,
  output logic [3:0] DIGIT,
  output logic [2:0] SELECT,
  output logic       PLACE,
  output logic       BLANK,
  output logic       UPD_PEND,
  output logic       FRAME_DONE
);

  logic tick_s;
  logic wrap_s;

  pos_t                         sel_q,    sel_d;
  logic                         pend_q,   pend_d;
  value_t [NUM_VALUES-1:0]      shadow_q, shadow_d;
  value_t [NUM_VALUES-1:0]      active_q, active_d;
  value_t                       digit_q,  digit_d;
  logic                         place_q,  place_d;
  logic                         blank_q,  blank_d;
  logic                         fdone_q,  fdone_d;

  seg_scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (EN),
    .tick_o (tick_s)
  );

  // Next-state for position, commit handshake, banks and display registers.
  always_comb begin
    sel_d    = sel_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    active_d = active_q;
    digit_d  = digit_q;
    place_d  = place_q;
    blank_d  = 1'b0;
    fdone_d  = 1'b0;

    wrap_s = tick_s & (sel_q == pos_t'(NUM_POS - 1));

    if (tick_s) begin
      sel_d = sel_q + pos_t'(1);
    end else begin
      sel_d = sel_q;
    end

    // A pending commit uses the shadow as registered before this edge. If no
    // commit was pending, an UPDATE seen at the boundary waits a full frame.
    if (wrap_s && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end else if (EN && UPDATE) begin
      pend_d   = 1'b1;
    end else begin
      pend_d   = pend_q;
    end

    if (WR_EN) begin
      shadow_d[WR_ADDR] = WR_DATA;
    end else begin
      shadow_d = shadow_q;
    end

    // Display registers are loaded from next-state so they line up with SELECT.
    digit_d = active_d[sel_d[2:1]];
    place_d = sel_d[0];
`ifdef SEG_SCAN_LZ_BLANK_EN
    blank_d = lz_blank(place_d, digit_d);
`else
    blank_d = 1'b0;
`endif
    fdone_d = wrap_s;
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q    <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      digit_q  <= 4'd0;
      place_q  <= 1'b0;
      blank_q  <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      digit_q  <= digit_d;
      place_q  <= place_d;
      blank_q  <= blank_d;
      fdone_q  <= fdone_d;
    end
  end

  assign DIGIT      = digit_q;
  assign SELECT     = sel_q;
  assign PLACE      = place_q;
  assign BLANK      = blank_q;
  assign UPD_PEND   = pend_q;
  assign FRAME_DONE = fdone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with SCAN_DIV=4. The reference model
// tracks the number of enabled cycles since reset; position and frame
// boundaries are derived from that count arithmetically.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int D     = 4;
  localparam int FRAME = 8 * D;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       WR_EN;
  logic [1:0] WR_ADDR;
  logic [3:0] WR_DATA;
  logic       UPDATE;
  logic [3:0] DIGIT;
  logic [2:0] SELECT;
  logic       PLACE;
  logic       BLANK;
  logic       UPD_PEND;
  logic       FRAME_DONE;

  seg_scan_ctrl #(.SCAN_DIV(D)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .UPDATE     (UPDATE),
    .DIGIT      (DIGIT),
    .SELECT     (SELECT),
    .PLACE      (PLACE),
    .BLANK      (BLANK),
    .UPD_PEND   (UPD_PEND),
    .FRAME_DONE (FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec;
  int n_fail;

  // Reference model state
  int m_cnt;
  int m_shadow [4];
  int m_active [4];
  bit m_pend;
  bit m_fd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_sel();
    return (m_cnt / D) % 8;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_pend = 0;
    m_fd   = 0;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
  endtask

  task automatic check_all();
    int s;
    int dg;
    int bl;
    s  = m_sel();
    dg = m_active[s / 2];
`ifdef SEG_SCAN_LZ_BLANK_EN
    bl = ((s % 2) == 1 && dg < 10) ? 1 : 0;
`else
    bl = 0;
`endif
    check_val("select", SELECT, s);
    check_val("digit", DIGIT, dg);
    check_val("place", PLACE, s % 2);
    check_val("blank", BLANK, bl);
    check_val("upd_pend", UPD_PEND, m_pend);
    check_val("frame_done", FRAME_DONE, m_fd);
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then check.
  task automatic step();
    bit w;
    @(posedge CLK);
    w = 0;
    if (EN) begin
      w = ((m_cnt + 1) % FRAME) == 0;
      if (w && m_pend) begin
        for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
        m_pend = 0;
      end else if (UPDATE) begin
        m_pend = 1;
      end
      m_cnt++;
    end
    m_fd = w;
    if (WR_EN) m_shadow[WR_ADDR] = int'(WR_DATA);
    #1;
    check_all();
  endtask

  task automatic idle();
    WR_EN   = 1'b0;
    WR_ADDR = 2'd0;
    WR_DATA = 4'd0;
    UPDATE  = 1'b0;
  endtask

  task automatic run_to_phase(input int p);
    int guard;
    guard = 0;
    while ((m_cnt % FRAME) != p && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) check_val("phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic upd);
    WR_EN   = 1'b1;
    WR_ADDR = a;
    WR_DATA = d;
    UPDATE  = upd;
    step();
    idle();
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      EN      = ($urandom_range(0, 9) != 0);
      WR_EN   = ($urandom_range(0, 3) == 0);
      WR_ADDR = 2'($urandom_range(0, 3));
      WR_DATA = 4'($urandom_range(0, 15));
      UPDATE  = ($urandom_range(0, 15) == 0);
      step();
    end
    idle();
    EN = 1'b1;
  endtask

  initial begin
    int n;
    logic [31:0] exp_blank7;
    n_vec  = 0;
    n_fail = 0;
    RST_N  = 1'b0;
    EN     = 1'b1;
    idle();
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_all();
    RST_N = 1'b1;

    // Commit waits for the frame boundary.
    wr(2'd1, 4'hC, 1'b0);
    run_to_phase(3 * D);
    UPDATE = 1'b1;
    step();
    UPDATE = 1'b0;
    check_val("c034_pend_set", UPD_PEND, 32'd1);
    run_to_phase(7 * D);
    check_val("c034_digit_old", DIGIT, 32'd0);
    check_val("c034_pend_held", UPD_PEND, 32'd1);
    run_to_phase(2 * D);
    check_val("c034_digit_s2", DIGIT, 32'hC);
    check_val("c034_place_s2", PLACE, 32'd0);
    check_val("c034_pend_clr", UPD_PEND, 32'd0);
    run_to_phase(3 * D);
    check_val("c034_digit_s3", DIGIT, 32'hC);
    check_val("c034_place_s3", PLACE, 32'd1);

    // Write in the commit cycle lands in shadow only.
    wr(2'd0, 4'h3, 1'b1);
    run_to_phase(FRAME - 1);
    wr(2'd0, 4'h5, 1'b0);
    check_val("c035_active0", DIGIT, 32'h3);
    check_val("c035_fdone", FRAME_DONE, 32'd1);
    check_val("c035_pend", UPD_PEND, 32'd0);
    UPDATE = 1'b1;
    step();
    UPDATE = 1'b0;
    run_to_phase(0);
    check_val("c035_shadow0", DIGIT, 32'h5);

    // Leading-zero blanking on the tens position of value 2.
`ifdef SEG_SCAN_LZ_BLANK_EN
    exp_blank7 = 32'd1;
`else
    exp_blank7 = 32'd0;
`endif
    wr(2'd2, 4'h7, 1'b1);
    run_to_phase(0);
    run_to_phase(5 * D);
    check_val("c036_digit7", DIGIT, 32'h7);
    check_val("c036_blank7", BLANK, exp_blank7);
    wr(2'd2, 4'hB, 1'b1);
    run_to_phase(0);
    run_to_phase(5 * D);
    check_val("c036_digitB", DIGIT, 32'hB);
    check_val("c036_blankB", BLANK, 32'd0);

    // Enable freeze mid-dwell at position 6.
    run_to_phase(6 * D + 1);
    EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("c037_sel_frozen", SELECT, 32'd6);
      check_val("c037_no_fdone", FRAME_DONE, 32'd0);
    end
    EN = 1'b1;
    n = 0;
    while (SELECT != 3'd7 && n < 20) begin
      step();
      n++;
    end
    check_val("c037_remaining_dwell", n, 32'd3);

    random_phase(400);

    // Asynchronous reset mid-scan with a pending commit.
    run_to_phase(3 * D + 2);
    wr(2'd3, 4'h9, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("c032_select", SELECT, 32'd0);
    check_val("c032_digit", DIGIT, 32'd0);
    check_val("c032_place", PLACE, 32'd0);
    check_val("c032_blank", BLANK, 32'd0);
    check_val("c032_pend", UPD_PEND, 32'd0);
    check_val("c032_fdone", FRAME_DONE, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    check_all();
    RST_N = 1'b1;
    n = 0;
    while (SELECT == 3'd0 && n < 20) begin
      step();
      n++;
    end
    check_val("c027_full_dwell", n, D);

    random_phase(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
